// File: rtl/psg_register_controller.sv
// ---------------------------------------------------------------------------
// psg_register_controller
//
// Bus-side write controller for an SN76489-style PSG. Bytes arrive over a
// valid/ready handshake and are decoded with the latch/data byte protocol
// into four attenuation registers, three tone frequency registers and one
// noise control register. After every accepted byte the controller holds
// wr_ready low for BUSY_CYCLES cycles to model the chip's busy window.
//
// Handshake: a byte transfers on a posedge where wr_valid && wr_ready.
// wr_ready depends only on the FSM state (and reset), never on wr_valid, so
// the writer may hold wr_valid and wr_data steady until the transfer happens.
//
// Ports:
//   clk               clock
//   reset             synchronous, active-high reset
//   wr_data[7:0]      write byte
//   wr_valid          write request
//   wr_ready          controller can accept a byte this cycle
//   attn_flat[15:0]   attenuation ch0..3 (ch n at [4n+3:4n], ch3 = noise)
//   tone_freq_flat    tone ch0..2 (ch n at [10n+9:10n])
//   noise_ctrl[2:0]   bit2 white/periodic, bits1:0 rate select
//   noise_use_tone2   noise clocked from tone channel 2 (rate == 2'b11)
//   noise_lfsr_reset  one-cycle pulse on every noise register write
// ---------------------------------------------------------------------------
module psg_register_controller #(
    parameter int BUSY_CYCLES              = 32,
    parameter int TONE_FREQUENCY_BITS      = 10,
    parameter int ATTENUATION_CONTROL_BITS = 4,
    parameter int NOISE_CONTROL_BITS       = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [7:0]                            wr_data,
    input  logic                                  wr_valid,
    output logic                                  wr_ready,
    output logic [4*ATTENUATION_CONTROL_BITS-1:0] attn_flat,
    output logic [3*TONE_FREQUENCY_BITS-1:0]      tone_freq_flat,
    output logic [NOISE_CONTROL_BITS-1:0]         noise_ctrl,
    output logic                                  noise_use_tone2,
    output logic                                  noise_lfsr_reset
);

    localparam int CNT_W = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'((BUSY_CYCLES > 0) ? BUSY_CYCLES - 1 : 0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // state is left as a named register so checkers can bind to it directly
    state_t                              state;
    logic [CNT_W-1:0]                    busy_cnt;
    logic [ATTENUATION_CONTROL_BITS-1:0] attn [4];
    logic [TONE_FREQUENCY_BITS-1:0]      tone [3];
    logic [1:0]                          lat_ch;
    logic                                lat_typ;
    logic                                accept;
    logic [1:0]                          tgt_ch;
    logic                                tgt_typ;

    assign wr_ready = (state == IDLE) && !reset;
    assign accept   = wr_valid && wr_ready;

    // A latch byte names its own target; a data byte reuses the latched one.
    assign tgt_ch  = wr_data[7] ? wr_data[6:5] : lat_ch;
    assign tgt_typ = wr_data[7] ? wr_data[4]   : lat_typ;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            busy_cnt         <= '0;
            lat_ch           <= 2'd0;
            lat_typ          <= 1'b0;
            noise_ctrl       <= '0;
            noise_lfsr_reset <= 1'b0;
            for (int i = 0; i < 4; i++) attn[i] <= '1;
            for (int i = 0; i < 3; i++) tone[i] <= '0;
        end else begin
            noise_lfsr_reset <= 1'b0;

            if (accept) begin
                if (wr_data[7]) begin
                    lat_ch  <= wr_data[6:5];
                    lat_typ <= wr_data[4];
                end

                if (tgt_typ) begin
                    for (int i = 0; i < 4; i++)
                        if (tgt_ch == 2'(i)) attn[i] <= wr_data[ATTENUATION_CONTROL_BITS-1:0];
                end else if (tgt_ch == 2'd3) begin
                    noise_ctrl       <= wr_data[NOISE_CONTROL_BITS-1:0];
                    noise_lfsr_reset <= 1'b1;
                end else begin
                    // Latch bytes carry the low nibble, data bytes the upper six bits.
                    for (int i = 0; i < 3; i++) begin
                        if (tgt_ch == 2'(i)) begin
                            if (wr_data[7]) tone[i][3:0] <= wr_data[3:0];
                            else            tone[i][TONE_FREQUENCY_BITS-1:4] <= wr_data[5:0];
                        end
                    end
                end
            end

            // Counter is loaded with BUSY_CYCLES-1 so that wr_ready stays
            // low for exactly BUSY_CYCLES cycles after the accept cycle.
            case (state)
                IDLE: begin
                    if (accept && (BUSY_CYCLES > 0)) begin
                        state    <= BUSY;
                        busy_cnt <= BUSY_LOAD;
                    end
                end
                BUSY: begin
                    if (busy_cnt == '0) state <= IDLE;
                    else                busy_cnt <= busy_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        attn_flat      = '0;
        tone_freq_flat = '0;
        for (int i = 0; i < 4; i++)
            attn_flat[ATTENUATION_CONTROL_BITS*i +: ATTENUATION_CONTROL_BITS] = attn[i];
        for (int i = 0; i < 3; i++)
            tone_freq_flat[TONE_FREQUENCY_BITS*i +: TONE_FREQUENCY_BITS] = tone[i];
    end

    assign noise_use_tone2 = (noise_ctrl[1:0] == 2'b11);

endmodule

// File: tb/tb_psg_register_controller.sv
// ---------------------------------------------------------------------------
// tb_psg_register_controller
//
// Two instances: a_* uses BUSY_CYCLES=0 (back-to-back writes, vector table
// with an expected-value queue), b_* uses BUSY_CYCLES=32 (busy window and
// reset-during-busy sequences). Both share clk and reset.
// ---------------------------------------------------------------------------
module tb_psg_register_controller;

    localparam int W = 51;

    logic        clk;
    logic        reset;

    logic [7:0]  a_data,  b_data;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [15:0] a_attn,  b_attn;
    logic [29:0] a_tone,  b_tone;
    logic [2:0]  a_noise, b_noise;
    logic        a_use2,  b_use2;
    logic        a_pulse, b_pulse;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic        valid;
        logic [7:0]  data;
        logic [15:0] attn;
        logic [29:0] tone;
        logic [2:0]  noise;
        logic        use2;
        logic        pulse;
    } vec_t;

    vec_t vecs[11];

    psg_register_controller #(.BUSY_CYCLES(0)) dut_a (
        .clk(clk), .reset(reset), .wr_data(a_data), .wr_valid(a_valid),
        .wr_ready(a_ready), .attn_flat(a_attn), .tone_freq_flat(a_tone),
        .noise_ctrl(a_noise), .noise_use_tone2(a_use2), .noise_lfsr_reset(a_pulse)
    );

    psg_register_controller #(.BUSY_CYCLES(32)) dut_b (
        .clk(clk), .reset(reset), .wr_data(b_data), .wr_valid(b_valid),
        .wr_ready(b_ready), .attn_flat(b_attn), .tone_freq_flat(b_tone),
        .noise_ctrl(b_noise), .noise_use_tone2(b_use2), .noise_lfsr_reset(b_pulse)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic check_a_reset_values(input string tag);
        check({tag, " a_attn"},  64'(a_attn),  64'hFFFF);
        check({tag, " a_tone"},  64'(a_tone),  64'h0);
        check({tag, " a_noise"}, 64'(a_noise), 64'h0);
        check({tag, " a_pulse"}, 64'(a_pulse), 64'h0);
    endtask

    task automatic check_b_reset_values(input string tag);
        check({tag, " b_attn"},  64'(b_attn),  64'hFFFF);
        check({tag, " b_tone"},  64'(b_tone),  64'h0);
        check({tag, " b_noise"}, 64'(b_noise), 64'h0);
        check({tag, " b_use2"},  64'(b_use2),  64'h0);
        check({tag, " b_pulse"}, 64'(b_pulse), 64'h0);
    endtask

    task automatic wait_b_ready(input string tag);
        int cnt;
        cnt = 0;
        while (b_ready !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, " wait b_ready timeout"}, 64'(b_ready), 64'h1);
    endtask

    // ---------------- vector table ----------------
    task automatic fill_vectors();
        //           valid  data    attn       tone           noise use2 pulse
        vecs[0]  = '{1'b1, 8'h8E, 16'hFFFF, 30'h0000000E, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h0F, 16'hFFFF, 30'h000000FE, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'hB5, 16'hFF5F, 30'h000000FE, 3'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h03, 16'hFF3F, 30'h000000FE, 3'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'hE6, 16'hFF3F, 30'h000000FE, 3'd6, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 8'h07, 16'hFF3F, 30'h000000FE, 3'd7, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 8'hC5, 16'hFF3F, 30'h005000FE, 3'd7, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 8'h7F, 16'hFF3F, 30'h3F5000FE, 3'd7, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'hFA, 16'hAF3F, 30'h3F5000FE, 3'd7, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'hE9, 16'hAF3F, 30'h3F5000FE, 3'd1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 8'h80, 16'hAF3F, 30'h3F5000FE, 3'd1, 1'b0, 1'b0};
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] e;
        int           lows;

        reset   = 1'b1;
        a_data  = 8'h00; a_valid = 1'b0;
        b_data  = 8'h00; b_valid = 1'b0;
        fill_vectors();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst a_ready", 64'(a_ready), 64'h0);
        check("rst b_ready", 64'(b_ready), 64'h0);
        check_a_reset_values("rst");
        check_b_reset_values("rst");
        reset = 1'b0;
        #1;
        check("post-rst a_ready", 64'(a_ready), 64'h1);
        check("post-rst b_ready", 64'(b_ready), 64'h1);
        @(negedge clk);

        // Table-driven back-to-back writes on the BUSY_CYCLES=0 instance
        for (int i = 0; i < 11; i++) begin
            check($sformatf("vec%0d a_ready", i), 64'(a_ready), 64'h1);
            a_valid = vecs[i].valid;
            a_data  = vecs[i].data;
            exp_q.push_back({vecs[i].attn, vecs[i].tone, vecs[i].noise, vecs[i].use2, vecs[i].pulse});
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("vec%0d attn",  i), 64'(a_attn),  64'(e[50:35]));
            check($sformatf("vec%0d tone",  i), 64'(a_tone),  64'(e[34:5]));
            check($sformatf("vec%0d noise", i), 64'(a_noise), 64'(e[4:2]));
            check($sformatf("vec%0d use2",  i), 64'(a_use2),  64'(e[1]));
            check($sformatf("vec%0d pulse", i), 64'(a_pulse), 64'(e[0]));
        end
        a_valid = 1'b0;

        // Busy window: C1 accepted, then 20 held high through BUSY
        check("busy pre b_ready", 64'(b_ready), 64'h1);
        b_data  = 8'hC1;
        b_valid = 1'b1;
        @(negedge clk);
        check("busy C1 tone", 64'(b_tone), 64'h00100000);
        b_data = 8'h20;
        lows = 0;
        while (b_ready === 1'b0 && lows < 100) begin
            lows++;
            @(negedge clk);
        end
        check("busy low cycles", 64'(lows), 64'd32);
        check("busy tone before 20", 64'(b_tone), 64'h00100000);
        @(negedge clk);
        check("busy 20 tone", 64'(b_tone), 64'h20100000);
        check("busy after 20 b_ready", 64'(b_ready), 64'h0);
        b_valid = 1'b0;

        // Reset 10 cycles into BUSY
        wait_b_ready("midrst");
        b_data  = 8'h9A;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        check("midrst attn0", 64'(b_attn), 64'hFFFA);
        repeat (9) @(negedge clk);
        check("midrst busy b_ready", 64'(b_ready), 64'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst in-reset b_ready", 64'(b_ready), 64'h0);
        reset = 1'b0;
        #1;
        check("midrst post b_ready", 64'(b_ready), 64'h1);
        check_b_reset_values("midrst");
        @(negedge clk);
        check("midrst held b_ready", 64'(b_ready), 64'h1);
        check_b_reset_values("midrst held");
        check_a_reset_values("midrst a");

        // Data byte straight after reset targets ch0 tone
        a_data  = 8'h3F;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        check("rst-data tone", 64'(a_tone), 64'h3F0);
        check("rst-data attn", 64'(a_attn), 64'hFFFF);
        check("rst-data pulse", 64'(a_pulse), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
